// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C codec-configuration responder.
//   state_t          FSM state encoding, also exported on the o_state debug port
//   WM8731_ADDR      7-bit device address the codec answers to
//   DEFAULT_NUM_REGS number of implemented 9-bit registers
//   *_W              frame field widths (device addr, register addr, data)
//   ack_next()       state that follows each ACK state
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_BYTE1     = 3'd3,
    S_ACK1      = 3'd4,
    S_BYTE2     = 3'd5,
    S_ACK2      = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  localparam logic [6:0] WM8731_ADDR      = 7'b0011010;
  localparam int         DEFAULT_NUM_REGS = 10;

  localparam int DEV_ADDR_W = 7;
  localparam int REG_ADDR_W = 7;
  localparam int DATA_W     = 9;

  // Each ACK slot hands over to the byte that follows it; after the data
  // ACK the frame is complete and anything further is ignored.
  function automatic state_t ack_next(input state_t s);
    case (s)
      S_ADDR_ACK: ack_next = S_BYTE1;
      S_ACK1:     ack_next = S_BYTE2;
      default:    ack_next = S_WAIT_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Bus front end: brings SCL/SDA into the clk domain and detects bus events.
//   clk, rst_n   system clock, async active-low reset
//   scl, sda     raw bus pins (asynchronous)
//   scl_rise     one-cycle pulse, SCL went 0->1
//   scl_fall     one-cycle pulse, SCL went 1->0
//   start        one-cycle pulse, SDA fell while SCL high
//   stop         one-cycle pulse, SDA rose while SCL high
//   sda_s        synchronized SDA, aligned with the event pulses
// Every output is registered, so a pin change is visible here 3 clocks later.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;

  // The idle bus is high on both lines, so the pipeline resets to 1s and
  // reset release does not fabricate an edge on a quiet bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
      sda_s    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
      scl_rise <= scl_sync[1] & ~scl_prev;
      scl_fall <= ~scl_sync[1] & scl_prev;
      // SCL must be high both before and after the SDA change.
      start    <= scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
      stop     <= scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
      sda_s    <= sda_sync[1];
    end
  end

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target decoding WM8731-style 24-bit configuration frames
// (device address + W, {reg[6:0], data[8]}, data[7:0]) into a shadow
// register file.
//   i_clk, i_rst_n   system clock (>= 8x SCL), async active-low reset
//   i_sclk, i_sdat   bus SCL/SDA inputs
//   o_sdat, o_oen    SDA drive: o_sdat is always 0, o_oen=1 pulls SDA low (ACK)
//   o_wr_valid/addr/data   committed register write
//   i_rd_addr, o_rd_data   combinational read port, 0 beyond NUM_REGS
//   o_state          FSM state (i2c_pkg::state_t encoding)
//   o_frame_count    committed frames, wraps at 255
// Write port handshake: o_wr_valid is a single-cycle strobe with no ready;
// o_wr_addr/o_wr_data are valid in that cycle and hold until the next write,
// and reg[] already holds the new value in that same cycle.
module i2c_codec_responder
  import i2c_pkg::*;
#(
  parameter logic [DEV_ADDR_W-1:0] DEV_ADDR = WM8731_ADDR,
  parameter int                    NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_sdat,
  output logic              o_sdat,
  output logic              o_oen,
  output logic              o_wr_valid,
  output logic [3:0]        o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic [3:0]        i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [2:0]        o_state,
  output logic [7:0]        o_frame_count
);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_line_sync u_line_sync (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .scl      (i_sclk),
    .sda      (i_sdat),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  state_t              state, state_d;
  logic [2:0]          bit_cnt, bit_cnt_d;
  logic [7:0]          shift, shift_d;
  logic [3:0]          reg_addr, reg_addr_d;
  logic                data_msb, data_msb_d;
  logic                oen, oen_d;
  logic                wr_valid, wr_valid_d;
  logic [3:0]          wr_addr, wr_addr_d;
  logic [DATA_W-1:0]   wr_data, wr_data_d;
  logic [7:0]          frame_count;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // The byte as it stands once the current bit is shifted in.
  logic [7:0]            byte_in;
  logic [DEV_ADDR_W-1:0] dev_field;
  logic [REG_ADDR_W-1:0] reg_field;

  assign byte_in   = {shift[6:0], sda_s};
  assign dev_field = byte_in[7:1];
  assign reg_field = byte_in[7:1];

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift;
    reg_addr_d = reg_addr;
    data_msb_d = data_msb;
    oen_d      = oen;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;

    // START outranks a coincident SCL edge; STOP likewise overrides any state.
    if (start) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      oen_d     = 1'b0;
    end else if (stop) begin
      state_d = S_IDLE;
      oen_d   = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_BYTE1, S_BYTE2, S_WAIT_STOP: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt + 3'd1;   // wraps to 0 on the 8th bit
            if (bit_cnt == 3'd7) begin
              if (state == S_ADDR) begin
                if (dev_field == DEV_ADDR && !byte_in[0]) state_d = S_ADDR_ACK;
                else                                      state_d = S_IDLE;
              end else if (state == S_BYTE1) begin
                if (reg_field < REG_ADDR_W'(NUM_REGS)) begin
                  reg_addr_d = reg_field[3:0];
                  data_msb_d = byte_in[0];
                  state_d    = S_ACK1;
                end else begin
                  state_d = S_IDLE;
                end
              end else if (state == S_BYTE2) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = reg_addr;
                wr_data_d  = {data_msb, byte_in};
                state_d    = S_ACK2;
              end
            end
          end
        end
        // The ACK state is entered on the 8th rising edge; the following
        // falling edge opens the ACK bit and the one after that closes it.
        // The ACK clock's own rising edge is deliberately not counted.
        S_ADDR_ACK, S_ACK1, S_ACK2: begin
          if (scl_fall) begin
            if (!oen) begin
              oen_d = 1'b1;
            end else begin
              oen_d   = 1'b0;
              state_d = ack_next(state);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      reg_addr    <= 4'd0;
      data_msb    <= 1'b0;
      oen         <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= 4'd0;
      wr_data     <= '0;
      frame_count <= 8'd0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      shift    <= shift_d;
      reg_addr <= reg_addr_d;
      data_msb <= data_msb_d;
      oen      <= oen_d;
      wr_valid <= wr_valid_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      if (wr_valid_d) frame_count <= frame_count + 8'd1;
    end
  end

  // Register file: the commit is the only writer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_valid_d) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_addr_d == 4'(i)) regs[i] <= wr_data_d;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_rd_addr == 4'(i)) o_rd_data = regs[i];
    end
  end

  assign o_sdat        = 1'b0;
  assign o_oen         = oen;
  assign o_wr_valid    = wr_valid;
  assign o_wr_addr     = wr_addr;
  assign o_wr_data     = wr_data;
  assign o_state       = state;
  assign o_frame_count = frame_count;

endmodule

// File: tb/tb_i2c_codec_responder.sv
module tb_i2c_codec_responder;

  localparam int         Q     = 8;            // clocks per quarter SCL period
  localparam int         NREGS = 10;
  localparam logic [6:0] DEV   = 7'b0011010;

  // ---------------- clock / reset / bus ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [3:0] rd_addr = 4'd0;

  logic       sdat_out, oen, wr_valid;
  logic [3:0] wr_addr;
  logic [8:0] wr_data, rd_data;
  logic [2:0] state;
  logic [7:0] frame_count;
  logic       sda_bus;

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and target.
  assign sda_bus = m_sda & ~oen;

  i2c_codec_responder dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sclk        (m_scl),
    .i_sdat        (sda_bus),
    .o_sdat        (sdat_out),
    .o_oen         (oen),
    .o_wr_valid    (wr_valid),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_state       (state),
    .o_frame_count (frame_count)
  );

  // ---------------- reference model + scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          oen_cycles = 0;
  logic [12:0] exp_q[$];
  logic [12:0] exp_e;
  logic [8:0]  exp_regs [16];
  logic [7:0]  exp_fc = 8'd0;

  // Every write strobe is matched against the next expected {addr,data}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (oen) oen_cycles++;
      if (wr_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected got addr=%0d data=%h required no write", wr_addr, wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== exp_e) begin
            n_err++;
            $display("FAIL wr_event got addr=%0d data=%h required addr=%0d data=%h",
                     wr_addr, wr_data, exp_e[12:9], exp_e[8:0]);
          end
        end
      end
    end
  end

  // Frame-level model: returns the expected ACK of each byte and records the
  // resulting write. bytes[31:24] is the first byte on the wire.
  function automatic logic [3:0] model_frame(input logic [31:0] bytes, input int nbytes);
    logic [7:0] b0, b1, b2;
    logic a0, a1, a2;
    b0 = bytes[31:24];
    b1 = bytes[23:16];
    b2 = bytes[15:8];
    a0 = (nbytes >= 1) && (b0[7:1] == DEV) && !b0[0];
    a1 = (nbytes >= 2) && a0 && (int'(b1[7:1]) < NREGS);
    a2 = (nbytes >= 3) && a1;
    if (a2) begin
      exp_regs[b1[4:1]] = {b1[0], b2};
      exp_fc = exp_fc + 8'd1;
      exp_q.push_back({b1[4:1], b1[0], b2});
    end
    return {1'b0, a2, a1, a0};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) exp_regs[i] = 9'd0;
    exp_fc = 8'd0;
    exp_q.delete();
  endfunction

  // ---------------- bus driver tasks ----------------
  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic bus_start();
    if (!m_scl) begin        // repeated START
      m_sda = 1'b1; wait_q();
      m_scl = 1'b1; wait_q();
    end
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q(); wait_q();
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q();
    seen = sda_bus; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic send_frame(input logic [31:0] bytes, input int nbytes, input bit do_stop,
                            output logic [3:0] acks);
    logic a;
    acks = 4'd0;
    bus_start();
    for (int i = 0; i < nbytes; i++) begin
      bus_byte(bytes[31-8*i -: 8], a);
      acks[i] = a;
    end
    if (do_stop) bus_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    n_vec++; if (oen !== 1'b0)        begin n_err++; $display("FAIL rst_oen got=%b exp=0", oen); end
    n_vec++; if (sdat_out !== 1'b0)   begin n_err++; $display("FAIL rst_sdat got=%b exp=0", sdat_out); end
    n_vec++; if (wr_valid !== 1'b0)   begin n_err++; $display("FAIL rst_wr_valid got=%b exp=0", wr_valid); end
    n_vec++; if (wr_addr !== 4'd0)    begin n_err++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
    n_vec++; if (wr_data !== 9'd0)    begin n_err++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
    n_vec++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
    n_vec++; if (state !== 3'd0)      begin n_err++; $display("FAIL rst_state got=%0d exp=0", state); end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      n_vec++; if (rd_data !== 9'd0) begin n_err++; $display("FAIL rst_reg%0d got=%h exp=000", a, rd_data); end
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] e, g;
    e = model_frame(32'h34_08_15_00, 3);
    send_frame(32'h34_08_15_00, 3, 1'b1, g);
    n_vec++; if (g[2:0] !== e[2:0]) begin n_err++; $display("FAIL single_acks got=%b exp=%b", g[2:0], e[2:0]); end
    rd_addr = 4'd4; #1;
    n_vec++; if (rd_data !== 9'h015) begin n_err++; $display("FAIL single_reg4 got=%h exp=015", rd_data); end
    n_vec++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL single_fc got=%0d exp=%0d", frame_count, exp_fc); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_missing_wr got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] cfg [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h012,
                             9'h000, 9'h000, 9'h00A, 9'h000, 9'h001};
    logic [31:0] fr;
    logic [3:0]  e, g;
    int acks_seen = 0;
    for (int r = 0; r < 10; r++) begin
      fr = {8'h34, 3'b000, 4'(r), cfg[r][8], cfg[r][7:0], 8'h00};
      e = model_frame(fr, 3);
      send_frame(fr, 3, 1'b1, g);
      acks_seen += int'(g[0]) + int'(g[1]) + int'(g[2]);
      n_vec++; if (g[2:0] !== e[2:0]) begin n_err++; $display("FAIL cfg_acks frame %0d got=%b exp=%b", r, g[2:0], e[2:0]); end
    end
    n_vec++; if (acks_seen != 30) begin n_err++; $display("FAIL cfg_ack_total got=%0d exp=30", acks_seen); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      n_vec++; if (rd_data !== exp_regs[a]) begin n_err++; $display("FAIL cfg_reg%0d got=%h exp=%h", a, rd_data, exp_regs[a]); end
    end
    n_vec++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL cfg_fc got=%0d exp=%0d", frame_count, exp_fc); end
  endtask

  task automatic test_wrong_device();
    logic [3:0] e, g;
    oen_cycles = 0;
    e = model_frame(32'h36_08_55_00, 3);
    send_frame(32'h36_08_55_00, 3, 1'b1, g);
    n_vec++; if (g[2:0] !== e[2:0]) begin n_err++; $display("FAIL wrongdev_acks got=%b exp=%b", g[2:0], e[2:0]); end
    n_vec++; if (oen_cycles != 0) begin n_err++; $display("FAIL wrongdev_oen got=%0d cycles exp=0", oen_cycles); end
    e = model_frame(32'h34_0A_3C_00, 3);
    send_frame(32'h34_0A_3C_00, 3, 1'b1, g);
    n_vec++; if (g[2:0] !== e[2:0]) begin n_err++; $display("FAIL wrongdev_next_acks got=%b exp=%b", g[2:0], e[2:0]); end
    rd_addr = 4'd5; #1;
    n_vec++; if (rd_data !== exp_regs[5]) begin n_err++; $display("FAIL wrongdev_reg5 got=%h exp=%h", rd_data, exp_regs[5]); end
  endtask

  task automatic test_read_and_range();
    logic [3:0] e, g;
    e = model_frame(32'h35_00_00_00, 1);
    send_frame(32'h35_00_00_00, 1, 1'b0, g);
    n_vec++; if (g[0] !== e[0]) begin n_err++; $display("FAIL read_bit_ack got=%b exp=%b", g[0], e[0]); end
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL read_bit_state got=%0d exp=0", state); end
    bus_stop();
    e = model_frame(32'h34_18_77_00, 3);
    send_frame(32'h34_18_77_00, 3, 1'b1, g);
    n_vec++; if (g[2:0] !== e[2:0]) begin n_err++; $display("FAIL range_acks got=%b exp=%b", g[2:0], e[2:0]); end
    n_vec++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL range_fc got=%0d exp=%0d", frame_count, exp_fc); end
  endtask

  task automatic test_abort();
    logic [3:0] e, g;
    logic       s;
    // Write of 9'h1FF to reg 2 cut short by STOP after byte 1.
    e = model_frame(32'h34_05_FF_00, 2);
    send_frame(32'h34_05_FF_00, 2, 1'b1, g);
    n_vec++; if (g[1:0] !== e[1:0]) begin n_err++; $display("FAIL abort_acks got=%b exp=%b", g[1:0], e[1:0]); end
    rd_addr = 4'd2; #1;
    n_vec++; if (rd_data !== exp_regs[2]) begin n_err++; $display("FAIL abort_reg2 got=%h exp=%h", rd_data, exp_regs[2]); end
    // Repeated START three bits into byte 1 must restart address decode.
    bus_start();
    bus_byte(8'h34, s);
    bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
    e = model_frame(32'h34_0F_23_00, 3);
    send_frame(32'h34_0F_23_00, 3, 1'b1, g);
    n_vec++; if (g[2:0] !== e[2:0]) begin n_err++; $display("FAIL rstart_acks got=%b exp=%b", g[2:0], e[2:0]); end
    rd_addr = 4'd7; #1;
    n_vec++; if (rd_data !== exp_regs[7]) begin n_err++; $display("FAIL rstart_reg7 got=%h exp=%h", rd_data, exp_regs[7]); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL abort_missing_wr got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] e, g;
    logic       s;
    bus_start();
    bus_byte(8'h34, s);
    for (int i = 7; i >= 0; i--) bus_bit(1'(8'h06 >> i), s);
    // Now inside the ACK1 low phase with the target driving SDA.
    n_vec++; if (oen !== 1'b1) begin n_err++; $display("FAIL midrst_pre_oen got=%b exp=1", oen); end
    @(negedge clk); #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (oen !== 1'b0) begin n_err++; $display("FAIL midrst_oen got=%b exp=0", oen); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      n_vec++; if (rd_data !== 9'd0) begin n_err++; $display("FAIL midrst_reg%0d got=%h exp=000", a, rd_data); end
    end
    @(negedge clk) rst_n = 1'b1;
    bus_stop();
    e = model_frame(32'h34_06_AB_00, 3);
    send_frame(32'h34_06_AB_00, 3, 1'b1, g);
    n_vec++; if (g[2:0] !== e[2:0]) begin n_err++; $display("FAIL midrst_next_acks got=%b exp=%b", g[2:0], e[2:0]); end
    rd_addr = 4'd3; #1;
    n_vec++; if (rd_data !== 9'h0AB) begin n_err++; $display("FAIL midrst_reg3 got=%h exp=0ab", rd_data); end
    n_vec++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL midrst_fc got=%0d exp=%0d", frame_count, exp_fc); end
  endtask

  task automatic test_random();
    logic [31:0] fr;
    logic [7:0]  b0;
    logic [8:0]  d;
    logic [3:0]  e, g;
    int          nb, sel;
    bit          stp;
    for (int f = 0; f < 16; f++) begin
      sel = $urandom_range(0, 5);
      b0 = (sel <= 2) ? 8'h34 : (sel == 3) ? 8'h35 : (sel == 4) ? 8'h36 : 8'($urandom_range(0, 255));
      d  = 9'($urandom_range(0, 511));
      fr = {b0, 3'b000, 4'($urandom_range(0, 12)), d, 8'($urandom_range(0, 255))};
      sel = $urandom_range(0, 7);
      nb  = (sel == 0) ? 1 : (sel == 1) ? 2 : (sel == 2) ? 4 : 3;
      stp = ($urandom_range(0, 3) != 0) || (f == 15);
      e = model_frame(fr, nb);
      send_frame(fr, nb, stp, g);
      n_vec++; if (g !== e) begin n_err++; $display("FAIL rand_acks frame %0d bytes=%h n=%0d got=%b exp=%b", f, fr, nb, g, e); end
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      n_vec++; if (rd_data !== exp_regs[a]) begin n_err++; $display("FAIL rand_reg%0d got=%h exp=%h", a, rd_data, exp_regs[a]); end
    end
    n_vec++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL rand_fc got=%0d exp=%0d", frame_count, exp_fc); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_missing_wr got=%0d pending exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_wrong_device();
    test_read_and_range();
    test_abort();
    test_reset_mid_frame();
    test_random();
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_codec_responder.md
# i2c_codec_responder

I2C write-only target that decodes the 24-bit WM8731-style configuration frames (7b device address, R/W, 7b register address, 9b data) and maintains a local copy of the register file. It sits on the same SCL/SDA pair as the codec-configuration master. It serves as a synthesizable codec stand-in for loopback testing and as a shadow register file that lets the design read back the programmed configuration. It oversamples the bus with the system clock and drives SDA only for ACK.

## Interface
- DEV_ADDR, 7'b0011010, 7-bit target address the block answers to
- NUM_REGS, 10, number of implemented 9-bit registers, addresses 0..NUM_REGS-1, max 16
- i_clk  in  1  system clock; must be at least 8x the SCL frequency
- i_rst_n  in  1  reset, asynchronous, active-low
- i_sclk  in  1  bus SCL, asynchronous to i_clk
- i_sdat  in  1  bus SDA, asynchronous to i_clk
- o_sdat  out  1  constant 0; the line is driven only while o_oen=1
- o_oen  out  1  1 = pull SDA low (ACK), 0 = released
- o_wr_valid  out  1  one-cycle pulse per committed register write
- o_wr_addr  out  4  register address of the committed write
- o_wr_data  out  9  data of the committed write
- i_rd_addr  in  4  combinational read-port address
- o_rd_data  out  9  register contents at i_rd_addr; 0 if address >= NUM_REGS
- o_state  out  3  current FSM state, for debug
- o_frame_count  out  8  committed frames, wraps 255->0

## Operation
- The sync front end applies a 2-FF synchronizer to SCL/SDA, then registers the previous value. It produces scl_rise, scl_fall, start (SDA 1->0 while SCL=1) and stop (SDA 0->1 while SCL=1).
- A data bit is sampled on scl_rise and shifted MSB-first into an 8-bit shift register. A 3-bit bit counter increments on scl_rise; 8 bits make a complete byte.
- FSM states: S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_WAIT_STOP.
- On start, from any state, including a repeated START: go to S_ADDR and clear the bit counter.
- On stop, from any state: go to S_IDLE and release o_oen.
- S_ADDR, byte complete:
  - If byte[7:1]==DEV_ADDR and byte[0]==0, go to S_ADDR_ACK.
  - Otherwise (mismatch or read), go to S_IDLE with no ACK (NACK).
- S_BYTE1, byte complete:
  - If byte[7:1] < NUM_REGS, latch reg_addr=byte[7:1] and data_msb=byte[0], then go to S_ACK1.
  - Otherwise NACK and go to S_IDLE.
- S_BYTE2, byte complete: go to S_ACK2 and commit the write. The commit writes reg[reg_addr]={data_msb,byte} and pulses o_wr_valid with the address and data. It also increments o_frame_count.
- ACK states:
  - On the scl_fall that ends bit 8, assert o_oen.
  - On the next scl_fall, which ends the ACK clock, release o_oen and advance to the next state: S_BYTE1, S_BYTE2 or S_WAIT_STOP respectively.
- S_WAIT_STOP: any further byte gets no ACK and writes nothing; the block waits for stop or start.
- Register write is the only state change of reg[]. The read port is purely combinational.

## Timing
- Reset values:
  - o_oen=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_frame_count=0.
  - State S_IDLE (o_state=0).
  - All regs 0.
- Bus edge detection latency: 3 i_clk cycles from the pin (2 sync + 1 edge register).
- o_oen rises 1 cycle after the detected scl_fall that ends bit 8, i.e. 4 cycles after the pin edge. It falls with the same latency after the next SCL falling edge.
- o_wr_valid is asserted exactly 1 cycle, on the cycle after the 8th scl_rise of byte 2. The data is in reg[] on that same cycle.
- Simultaneous start and scl edge in one cycle: start wins.
- Reset mid-frame: the bus is released immediately (async), no partial write, and the block idles until the next START.
- A frame aborted by STOP/START before the ACK2 commit leaves reg[] unchanged.

## Structure
- Shared package i2c_pkg holds:
  - the FSM state enum, 3 bits;
  - the WM8731 device address localparam;
  - the default register count;
  - the frame field widths (address 7, register address 7, data 9).
- One sub-module: i2c_line_sync. It contains the synchronizers and the edge, start and stop detection, and outputs scl_rise, scl_fall, start, stop and sda_s.
- The register file is inline: NUM_REGS x 9 flops.

## Test plan
- Frame 0x34,0x08,0x15 (reg 4 <= 9'h015): three ACKs. o_wr_valid pulses once with addr 4, data 9'h015; o_rd_data at addr 4 = 9'h015; o_frame_count=1.
- Ten-frame configuration sequence from the codec-configuration master, run back-to-back on the same bus: thirty ACKs, and the read port returns all ten programmed values (e.g. reg 0 = 9'h097, reg 9 = 9'h001).
- Address 0x36, a wrong device: no o_oen and no write. The following valid frame is still accepted.
- Read bit set (0x35): NACK, state returns to S_IDLE. Register address 0x0C, which is >= NUM_REGS: address ACKed, byte1 NACKed, no write.
- STOP after byte 1 of a write of 9'h1FF to reg 2: reg 2 stays at its prior value and no o_wr_valid. A repeated START mid-byte restarts address decode.
- Assert i_rst_n low during S_ACK1: o_oen drops the same cycle, all regs read 0, and the next full frame commits normally.
